// File: rtl/tx_polyphase_shaper_if.sv
// Strobe/symbol inputs and shaped-sample outputs of the transmit polyphase shaper.
interface tx_polyphase_shaper_if #(
    parameter int WIDTH = 18
);
    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic [1:0]              sym_in;
    logic signed [WIDTH-1:0] y;
    logic                    y_valid;
    logic [1:0]              phase;

    modport master (output sam_clk_en, sym_clk_en, sym_in, input y, y_valid, phase);
    modport slave  (input sam_clk_en, sym_clk_en, sym_in, output y, y_valid, phase);
endinterface

// File: rtl/tx_polyphase_shaper.sv
// 4-ASK pulse-shaping interpolator: x4 polyphase FIR, one output accumulated over
// four sys_clk cycles, TERMS multiplier-free products per cycle.
module tx_polyphase_shaper #(
    parameter int                    WIDTH  = 18,
    parameter int                    LENGTH = 101,
    parameter int                    SPS    = 4,
    parameter int                    ACCW   = 26,
    parameter int                    SHIFT  = 1,
    parameter logic [LENGTH*WIDTH-1:0] COEFFS = '0
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    tx_polyphase_shaper_if.slave bus
);
    localparam int NSYM  = (LENGTH + SPS - 1) / SPS;
    localparam int TERMS = (NSYM + SPS - 1) / SPS;

    localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] Y_MIN = ACCW'(-(2 ** (WIDTH - 1)));

    logic signed [2:0]       sd [NSYM];
    logic signed [ACCW-1:0]  acc_q;
    logic signed [ACCW-1:0]  partial;
    logic [1:0]              cnt_q;
    logic [1:0]              phase_q;
    logic signed [WIDTH-1:0] y_q;
    logic                    y_valid_q;

    function automatic logic signed [2:0] map_symbol(input logic [1:0] s);
        case (s)
            2'b00:   return -3'sd3;
            2'b01:   return -3'sd1;
            2'b10:   return 3'sd1;
            default: return 3'sd3;
        endcase
    endfunction

    function automatic int sym_index(input logic [1:0] c, input int i);
        return int'(c) * TERMS + i;
    endfunction

    function automatic int tap_index(input logic [1:0] c, input logic [1:0] p, input int i);
        return SPS * sym_index(c, i) + int'(p);
    endfunction

    function automatic logic signed [WIDTH-1:0] coef(input int tap);
        return $signed(COEFFS[tap*WIDTH +: WIDTH]);
    endfunction

    // Level times coefficient using only shift-and-add: |L| is 1 or 3.
    function automatic logic signed [ACCW-1:0] scale(input logic signed [2:0] lvl,
                                                     input logic signed [WIDTH-1:0] c);
        logic signed [ACCW-1:0] base;
        logic signed [ACCW-1:0] mag;
        base = ACCW'(c);
        mag  = (lvl == 3'sd3 || lvl == -3'sd3) ? (base <<< 1) + base : base;
        if (lvl == 3'sd0) return '0;
        return lvl[2] ? -mag : mag;
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = v >>> SHIFT;
        if (s > Y_MAX) return WIDTH'(Y_MAX);
        if (s < Y_MIN) return WIDTH'(Y_MIN);
        return WIDTH'(s);
    endfunction

    always_comb begin
        // NOTE: default assigned first so no path leaves partial unassigned (no latch).
        partial = '0;
        for (int i = 0; i < TERMS; i++) begin
            if (sym_index(cnt_q, i) < NSYM && tap_index(cnt_q, phase_q, i) < LENGTH) begin
                partial = partial + scale(sd[sym_index(cnt_q, i)],
                                          coef(tap_index(cnt_q, phase_q, i)));
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            // NOTE: the delay line is cleared too, so the first output sees an all-zero history.
            for (int k = 0; k < NSYM; k++) sd[k] <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every sd[k] <= sd[k-1] reads the pre-edge value.
            y_valid_q <= bus.sam_clk_en;
            if (bus.sam_clk_en) begin
                y_q   <= saturate(acc_q + partial);
                acc_q <= '0;
                cnt_q <= '0;
                if (bus.sym_clk_en) begin
                    sd[0] <= map_symbol(bus.sym_in);
                    for (int k = 1; k < NSYM; k++) sd[k] <= sd[k-1];
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_q + 2'd1;
                end
            end else begin
                acc_q <= acc_q + partial;
                if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.phase   = phase_q;
endmodule

// File: tb/tb_tx_polyphase_shaper.sv
// Randomized bench for tx_polyphase_shaper: three coefficient sets driven by one
// symbol stream, each compared against a direct-convolution reference model.
module tb_tx_polyphase_shaper;
    localparam int WIDTH  = 18;
    localparam int LENGTH = 101;
    localparam int SPS    = 4;
    localparam int ACCW   = 26;
    localparam int NSYM   = 26;
    localparam int Y_HI   = 131071;
    localparam int Y_LO   = -131072;

    // Set 0: general taps, set 1: single tap h[0]=1000, set 2: all taps 32767.
    function automatic int coef_val(input int kind, input int k);
        int v;
        case (kind)
            0: begin
                v = ((k * 40503 + 12345) % 65536) - 32768;
                if (k == 0)  v = 73;
                if (k == 1)  v = -7;
                if (k == 50) v = 39137;
            end
            1:       v = (k == 0) ? 1000 : 0;
            default: v = 32767;
        endcase
        return v;
    endfunction

    function automatic logic [LENGTH*WIDTH-1:0] pack_coeffs(input int kind);
        logic [LENGTH*WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < LENGTH; k++) v[k*WIDTH +: WIDTH] = WIDTH'(coef_val(kind, k));
        return v;
    endfunction

    function automatic int shift_of(input int d);
        return (d == 2) ? 0 : 1;
    endfunction

    logic       sys_clk;
    logic       reset_n;
    logic       sam_clk_en;
    logic       sym_clk_en;
    logic [1:0] sym_in;

    tx_polyphase_shaper_if #(.WIDTH(WIDTH)) bus0 ();
    tx_polyphase_shaper_if #(.WIDTH(WIDTH)) bus1 ();
    tx_polyphase_shaper_if #(.WIDTH(WIDTH)) bus2 ();

    assign bus0.sam_clk_en = sam_clk_en;
    assign bus0.sym_clk_en = sym_clk_en;
    assign bus0.sym_in     = sym_in;
    assign bus1.sam_clk_en = sam_clk_en;
    assign bus1.sym_clk_en = sym_clk_en;
    assign bus1.sym_in     = sym_in;
    assign bus2.sam_clk_en = sam_clk_en;
    assign bus2.sym_clk_en = sym_clk_en;
    assign bus2.sym_in     = sym_in;

    tx_polyphase_shaper #(.WIDTH(WIDTH), .LENGTH(LENGTH), .SPS(SPS), .ACCW(ACCW),
                          .SHIFT(1), .COEFFS(pack_coeffs(0)))
        dut0 (.sys_clk(sys_clk), .reset_n(reset_n), .bus(bus0));
    tx_polyphase_shaper #(.WIDTH(WIDTH), .LENGTH(LENGTH), .SPS(SPS), .ACCW(ACCW),
                          .SHIFT(1), .COEFFS(pack_coeffs(1)))
        dut1 (.sys_clk(sys_clk), .reset_n(reset_n), .bus(bus1));
    tx_polyphase_shaper #(.WIDTH(WIDTH), .LENGTH(LENGTH), .SPS(SPS), .ACCW(ACCW),
                          .SHIFT(0), .COEFFS(pack_coeffs(2)))
        dut2 (.sys_clk(sys_clk), .reset_n(reset_n), .bus(bus2));

    logic signed [WIDTH-1:0] y_obs  [3];
    logic                    yv_obs [3];
    logic [1:0]              ph_obs [3];
    assign y_obs[0]  = bus0.y;
    assign y_obs[1]  = bus1.y;
    assign y_obs[2]  = bus2.y;
    assign yv_obs[0] = bus0.y_valid;
    assign yv_obs[1] = bus1.y_valid;
    assign yv_obs[2] = bus2.y_valid;
    assign ph_obs[0] = bus0.phase;
    assign ph_obs[1] = bus1.phase;
    assign ph_obs[2] = bus2.phase;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference state: symbol levels newest-first, current branch, expected outputs.
    int hist [NSYM];
    int ph_m;
    int y_m  [3];
    int yv_m;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model_y(input int d);
        int s;
        s = 0;
        for (int j = 0; j < NSYM; j++)
            if (SPS * j + ph_m < LENGTH) s += hist[j] * coef_val(d, SPS * j + ph_m);
        s = s >>> shift_of(d);
        if (s > Y_HI) s = Y_HI;
        if (s < Y_LO) s = Y_LO;
        return s;
    endfunction

    // One sys_clk cycle: drive, advance the model at the edge, compare half a cycle later.
    task automatic tick(input logic rst_v, input logic sam, input logic sym, input logic [1:0] code);
        reset_n    = rst_v;
        sam_clk_en = sam;
        sym_clk_en = sym;
        sym_in     = code;
        @(posedge sys_clk);
        if (!rst_v) begin
            for (int j = 0; j < NSYM; j++) hist[j] = 0;
            for (int d = 0; d < 3; d++) y_m[d] = 0;
            ph_m = 0;
            yv_m = 0;
        end else begin
            yv_m = int'(sam);
            if (sam) begin
                for (int d = 0; d < 3; d++) y_m[d] = model_y(d);
                if (sym) begin
                    for (int j = NSYM - 1; j > 0; j--) hist[j] = hist[j-1];
                    hist[0] = 2 * int'(code) - 3;
                    ph_m = 0;
                end else begin
                    ph_m = (ph_m + 1) % 4;
                end
            end
        end
        @(negedge sys_clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("y[%0d]", d), y_obs[d], y_m[d]);
            check($sformatf("y_valid[%0d]", d), yv_obs[d], yv_m);
            check($sformatf("phase[%0d]", d), ph_obs[d], ph_m);
        end
    endtask

    // One output sample: strobe cycle then three quiet cycles with stray symbol strobes.
    task automatic sample(input logic sym, input logic [1:0] code);
        tick(1'b1, 1'b1, sym, code);
        for (int k = 0; k < 3; k++)
            tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        sym_in     = 2'b00;
        ph_m       = 0;
        yv_m       = 0;
        for (int j = 0; j < NSYM; j++) hist[j] = 0;
        for (int d = 0; d < 3; d++) y_m[d] = 0;

        for (int k = 0; k < 6; k++) tick(1'b0, 1'(k % 4 == 0), 1'b0, 2'b11);
        check("rst_y", y_obs[0], 0);
        check("rst_y_valid", yv_obs[0], 0);
        check("rst_phase", ph_obs[0], 0);

        for (int k = 0; k < 4; k++) begin
            sample(1'b0, 2'($urandom_range(0, 3)));
            check("post_rst_zero", y_obs[0], 0);
        end

        sample(1'b1, 2'b11);
        sample(1'b0, 2'b00);
        check("impulse_h0", y_obs[0], 109);
        check("level_11", y_obs[1], 1500);
        sample(1'b0, 2'b00);
        check("impulse_h1", y_obs[0], -11);
        check("phase_before_resync", ph_obs[0], 2);

        sample(1'b1, 2'b00);
        check("resync_from_2", ph_obs[0], 0);
        sample(1'b0, 2'b00);
        check("level_00", y_obs[1], -1500);
        sample(1'b1, 2'b01);
        check("resync_from_1", ph_obs[0], 0);
        sample(1'b0, 2'b00);
        check("level_01", y_obs[1], -500);
        sample(1'b0, 2'b00);
        check("level_tail", y_obs[1], 0);
        sample(1'b1, 2'b10);
        sample(1'b0, 2'b00);
        check("level_10", y_obs[1], 500);

        repeat (30) sample(1'b1, 2'b11);
        check("sat_pos", y_obs[2], 131071);
        repeat (30) sample(1'b1, 2'b00);
        check("sat_neg", y_obs[2], -131072);

        for (int n = 0; n < 400; n++)
            sample(1'((n % 4 == 0) || ($urandom_range(0, 15) == 0)), 2'($urandom_range(0, 3)));

        tick(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'(k == 2), 1'b1, 2'b11);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("mid_rst_y[%0d]", d), y_obs[d], 0);
            check($sformatf("mid_rst_y_valid[%0d]", d), yv_obs[d], 0);
            check($sformatf("mid_rst_phase[%0d]", d), ph_obs[d], 0);
        end
        for (int k = 0; k < 4; k++) begin
            sample(1'b0, 2'($urandom_range(0, 3)));
            check("mid_rst_zero", y_obs[2], 0);
        end

        for (int n = 0; n < 100; n++)
            sample(1'((n % 4 == 0) || ($urandom_range(0, 15) == 0)), 2'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
